// File: rtl/done_return_ctrl.sv
// Request-done completion engine. Tracks issued request indices, pairs
// in-order PHY read beats with the oldest outstanding read, retires writes
// after a fixed latency, and emits at most one completion per cycle.

package types_def;
  typedef enum logic {
    read  = 1'b0,
    write = 1'b1
  } r_type;
endpackage

module done_return_ctrl
  import types_def::*;
#(
  parameter int RD_DEPTH = 16,
  parameter int WR_DEPTH = 16,
  parameter int WR_LAT   = 4,
  parameter int DATA_W   = 32,
  parameter int IDX_W    = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            issue_valid,
  input  r_type                           issue_type,
  input  logic [IDX_W-1:0]                issue_index,
  output logic                            issue_ready,
  input  logic                            rd_data_valid,
  input  logic [DATA_W-1:0]               rd_data,
  output logic                            request_done_valid,
  output r_type                           the_type,
  output logic [DATA_W-1:0]               in_data,
  output logic [IDX_W-1:0]                index,
  output logic [$clog2(RD_DEPTH+1)-1:0]   rd_outstanding,
  output logic                            err_unexpected
);

  localparam int RD_CW = $clog2(RD_DEPTH + 1);
  localparam int WR_CW = $clog2(WR_DEPTH + 1);
  localparam int RD_PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int WR_PW = (WR_DEPTH > 1) ? $clog2(WR_DEPTH) : 1;

  // Read-tag FIFO
  logic [IDX_W-1:0] rd_mem [RD_DEPTH];
  logic [RD_PW-1:0] rd_wp, rd_rp;
  logic [RD_CW-1:0] rd_count;

  // Write-done FIFO (writes that have finished their latency)
  logic [IDX_W-1:0] wf_mem [WR_DEPTH];
  logic [WR_PW-1:0] wf_wp, wf_rp;
  logic [WR_CW-1:0] wf_count;

  // Writes in flight: latency pipe plus write-done FIFO
  logic [WR_CW-1:0] wr_count;

  // Holds issue_ready low until the first edge after reset release
  logic ready_q;

  logic             rd_push, rd_pop, rd_unexp;
  logic             wr_accept, wf_push, wf_pop;
  logic [IDX_W-1:0] wf_push_idx;

  function automatic logic [RD_PW-1:0] rd_next(input logic [RD_PW-1:0] p);
    return (p == RD_PW'(RD_DEPTH - 1)) ? '0 : p + RD_PW'(1);
  endfunction

  function automatic logic [WR_PW-1:0] wf_next(input logic [WR_PW-1:0] p);
    return (p == WR_PW'(WR_DEPTH - 1)) ? '0 : p + WR_PW'(1);
  endfunction

  // Ready depends only on registered occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign issue_ready = ready_q
                     && (rd_count < RD_CW'(RD_DEPTH))
                     && (wr_count < WR_CW'(WR_DEPTH));

  assign rd_outstanding = rd_count;

  // Accept, pop and arbitration decode; read beats always win over writes.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned, which would infer a latch.
    rd_push   = 1'b0;
    wr_accept = 1'b0;
    rd_pop    = 1'b0;
    rd_unexp  = 1'b0;
    wf_pop    = 1'b0;
    if (issue_valid && issue_ready) begin
      rd_push   = (issue_type == read);
      wr_accept = (issue_type == write);
    end
    if (rd_data_valid) begin
      rd_pop   = (rd_count != '0);
      rd_unexp = (rd_count == '0);
    end
    wf_pop = !rd_pop && (wf_count != '0);
  end

  // Write latency pipe: WR_LAT-1 register stages, with the write-done FIFO
  // acting as the final stage so a write is eligible WR_LAT edges after issue.
  if (WR_LAT > 1) begin : g_pipe
    localparam int N = WR_LAT - 1;
    logic [N-1:0]     pipe_v;
    logic [IDX_W-1:0] pipe_idx [N];

    // Valid bits shift one stage per cycle.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        pipe_v <= '0;
      end else begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of the previous one.
        pipe_v[0] <= wr_accept;
        for (int i = 1; i < N; i++) pipe_v[i] <= pipe_v[i-1];
      end
    end

    // Index payload follows the valid bits; qualified by pipe_v.
    always_ff @(posedge clk) begin
      pipe_idx[0] <= issue_index;
      for (int i = 1; i < N; i++) pipe_idx[i] <= pipe_idx[i-1];
    end

    assign wf_push     = pipe_v[N-1];
    assign wf_push_idx = pipe_idx[N-1];
  end else begin : g_direct
    assign wf_push     = wr_accept;
    assign wf_push_idx = issue_index;
  end

  // FIFO storage arrays.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are not reset; pointers and counts define which entries are valid, so stale contents are never observed.
    if (rd_push) rd_mem[rd_wp] <= issue_index;
    if (wf_push) wf_mem[wf_wp] <= wf_push_idx;
  end

  // Read-tag FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_wp    <= '0;
      rd_rp    <= '0;
      rd_count <= '0;
    end else begin
      if (rd_push) rd_wp <= rd_next(rd_wp);
      if (rd_pop)  rd_rp <= rd_next(rd_rp);
      case ({rd_push, rd_pop})
        2'b10:   rd_count <= rd_count + RD_CW'(1);
        2'b01:   rd_count <= rd_count - RD_CW'(1);
        default: rd_count <= rd_count;
      endcase
    end
  end

  // Write-done FIFO pointers, its occupancy and total writes in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wf_wp    <= '0;
      wf_rp    <= '0;
      wf_count <= '0;
      wr_count <= '0;
    end else begin
      if (wf_push) wf_wp <= wf_next(wf_wp);
      if (wf_pop)  wf_rp <= wf_next(wf_rp);
      case ({wf_push, wf_pop})
        2'b10:   wf_count <= wf_count + WR_CW'(1);
        2'b01:   wf_count <= wf_count - WR_CW'(1);
        default: wf_count <= wf_count;
      endcase
      case ({wr_accept, wf_pop})
        2'b10:   wr_count <= wr_count + WR_CW'(1);
        2'b01:   wr_count <= wr_count - WR_CW'(1);
        default: wr_count <= wr_count;
      endcase
    end
  end

  // Ready enable rises at the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  // Completion output registers; payload holds when nothing completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      request_done_valid <= 1'b0;
      the_type           <= read;
      in_data            <= '0;
      index              <= '0;
      err_unexpected     <= 1'b0;
    end else begin
      request_done_valid <= rd_pop || wf_pop;
      if (rd_pop) begin
        the_type <= read;
        in_data  <= rd_data;
        index    <= rd_mem[rd_rp];
      end else if (wf_pop) begin
        the_type <= write;
        in_data  <= '0;
        index    <= wf_mem[wf_rp];
      end
      if (rd_unexp) err_unexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_done_return_ctrl.sv
// Self-checking bench for done_return_ctrl: directed vector table, hand
// sequences for fill/drain and reset, and randomized traffic compared against
// a queue-based reference model.

module tb_done_return_ctrl;
  import types_def::*;

  localparam int RD_DEPTH = 16;
  localparam int WR_DEPTH = 16;
  localparam int WR_LAT   = 4;
  localparam int DATA_W   = 32;
  localparam int IDX_W    = 6;
  localparam int RC_W     = $clog2(RD_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              issue_valid = 1'b0;
  r_type             issue_type = read;
  logic [IDX_W-1:0]  issue_index = '0;
  logic              issue_ready;
  logic              rd_data_valid = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              request_done_valid;
  r_type             the_type;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  index;
  logic [RC_W-1:0]   rd_outstanding;
  logic              err_unexpected;

  always #5 clk = ~clk;

  done_return_ctrl #(
    .RD_DEPTH(RD_DEPTH), .WR_DEPTH(WR_DEPTH), .WR_LAT(WR_LAT),
    .DATA_W(DATA_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_type(issue_type),
    .issue_index(issue_index), .issue_ready(issue_ready),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .request_done_valid(request_done_valid), .the_type(the_type),
    .in_data(in_data), .index(index),
    .rd_outstanding(rd_outstanding), .err_unexpected(err_unexpected)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic              dv;
    logic              ty;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
    logic [RC_W-1:0]   rdo;
    logic              rdy;
    logic              err;
  } obs_t;

  // ---------------- reference model ----------------
  typedef struct {
    logic [IDX_W-1:0] idx;
    int               elig;
  } wr_ent_t;

  logic [IDX_W-1:0]  rd_q[$];
  wr_ent_t           wr_q[$];
  int                cyc = 0;
  bit                ready_en = 0;
  logic              m_dv;
  r_type             m_type;
  logic [DATA_W-1:0] m_data;
  logic [IDX_W-1:0]  m_idx;
  logic              m_err;

  function automatic bit model_ready();
    return ready_en && (rd_q.size() < RD_DEPTH) && (wr_q.size() < WR_DEPTH);
  endfunction

  task automatic model_clear();
    rd_q.delete();
    wr_q.delete();
    ready_en = 0;
    m_dv = 1'b0; m_type = read; m_data = '0; m_idx = '0; m_err = 1'b0;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o = {m_dv, logic'(m_type), m_data, m_idx, RC_W'(rd_q.size()), logic'(model_ready()), m_err};
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = {request_done_valid, logic'(the_type), in_data, index, rd_outstanding, issue_ready, err_unexpected};
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("dv=%0b type=%0d data=%0h idx=%0d rdo=%0d rdy=%0b err=%0b",
                     o.dv, o.ty, o.data, o.idx, o.rdo, o.rdy, o.err);
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got {%s} expected {%s}", name, $time, fmt(act), fmt(exp));
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: the model applies the completion rules to the inputs sampled
  // at the edge, then DUT outputs are compared 1 ns later.
  task automatic step();
    bit      acc;
    wr_ent_t w;
    @(posedge clk);
    if (rst) begin
      acc = issue_valid && model_ready();
      cyc++;
      if (rd_data_valid && rd_q.size() > 0) begin
        m_dv = 1'b1; m_type = read; m_data = rd_data; m_idx = rd_q.pop_front();
      end else begin
        if (rd_data_valid) m_err = 1'b1;
        if (wr_q.size() > 0 && wr_q[0].elig <= cyc) begin
          w = wr_q.pop_front();
          m_dv = 1'b1; m_type = write; m_data = '0; m_idx = w.idx;
        end else begin
          m_dv = 1'b0;
        end
      end
      if (acc) begin
        if (issue_type == read) rd_q.push_back(issue_index);
        else begin
          w.idx = issue_index; w.elig = cyc + WR_LAT;
          wr_q.push_back(w);
        end
      end
      ready_en = 1;
    end
    #1;
    check_obs("model", dut_obs(), model_obs());
  endtask

  task automatic drive(input bit iv, input r_type it, input logic [IDX_W-1:0] ii,
                       input bit rv, input logic [DATA_W-1:0] rd);
    issue_valid = iv; issue_type = it; issue_index = ii;
    rd_data_valid = rv; rd_data = rd;
  endtask

  task automatic idle();
    drive(0, read, '0, 0, '0);
  endtask

  // Asserts reset asynchronously, holds it for n edges, then releases.
  task automatic apply_reset(input int n);
    rst = 1'b0;
    model_clear();
    #1;
    check_obs("reset_async", dut_obs(), model_obs());
    check("reset_ready_low", issue_ready, 1'b0);
    repeat (n) step();
    rst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit                iv;
    r_type             it;
    logic [IDX_W-1:0]  ii;
    bit                rv;
    logic [DATA_W-1:0] rd;
    obs_t              exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit iv, r_type it, int ii, bit rv, int rd,
                             bit edv, r_type ety, int edata, int eidx,
                             int erdo, bit erdy, bit eerr);
    vec_t x;
    x.iv = iv; x.it = it; x.ii = IDX_W'(ii); x.rv = rv; x.rd = DATA_W'(rd);
    x.exp = {edv, logic'(ety), DATA_W'(edata), IDX_W'(eidx), RC_W'(erdo), erdy, eerr};
    return x;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_clear();
    idle();
    apply_reset(2);
    step();
    check("ready_after_release", issue_ready, 1'b1);

    // single read, write latency, collision, unexpected data, same-cycle read+data
    tbl.push_back(v(1, read,  5, 0, 0,     0, read,  0,     0,  1, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, read,  0,     0,  1, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, read,  0,     0,  1, 1, 0));
    tbl.push_back(v(0, read,  0, 1, 10,    1, read,  10,    5,  0, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, read,  10,    5,  0, 1, 0));
    tbl.push_back(v(1, write, 7, 0, 0,     0, read,  10,    5,  0, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, read,  10,    5,  0, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, read,  10,    5,  0, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, read,  10,    5,  0, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     1, write, 0,     7,  0, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, write, 0,     7,  0, 1, 0));
    tbl.push_back(v(1, read,  2, 0, 0,     0, write, 0,     7,  1, 1, 0));
    tbl.push_back(v(1, write, 9, 0, 0,     0, write, 0,     7,  1, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, write, 0,     7,  1, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, write, 0,     7,  1, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, write, 0,     7,  1, 1, 0));
    tbl.push_back(v(0, read,  0, 1, 'hAB,  1, read,  'hAB,  2,  0, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     1, write, 0,     9,  0, 1, 0));
    tbl.push_back(v(0, read,  0, 0, 0,     0, write, 0,     9,  0, 1, 0));
    tbl.push_back(v(0, read,  0, 1, 'h55,  0, write, 0,     9,  0, 1, 1));
    tbl.push_back(v(0, read,  0, 0, 0,     0, write, 0,     9,  0, 1, 1));
    tbl.push_back(v(1, read, 12, 0, 0,     0, write, 0,     9,  1, 1, 1));
    tbl.push_back(v(0, read,  0, 1, 'h77,  1, read,  'h77, 12,  0, 1, 1));
    tbl.push_back(v(1, read, 20, 1, 'h99,  0, read,  'h77, 12,  1, 1, 1));
    tbl.push_back(v(0, read,  0, 1, 'h31,  1, read,  'h31, 20,  0, 1, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].it, tbl[i].ii, tbl[i].rv, tbl[i].rd);
      step();
      check_obs($sformatf("vec%0d", i), dut_obs(), tbl[i].exp);
    end
    idle();

    // Fill the read-tag FIFO, then drain it in order.
    apply_reset(2);
    step();
    for (int i = 0; i < RD_DEPTH; i++) begin
      drive(1, read, IDX_W'(i), 0, '0);
      step();
    end
    check("full_ready", issue_ready, 1'b0);
    check("full_rdo", rd_outstanding, RD_DEPTH);
    // Issue attempt coincides with the first pop: must not be accepted.
    drive(1, read, IDX_W'(63), 1, DATA_W'(100));
    step();
    check("drain0_idx", index, 0);
    check("drain0_data", in_data, 100);
    check("drain0_rdo", rd_outstanding, RD_DEPTH - 1);
    check("ready_after_pop", issue_ready, 1'b1);
    for (int i = 1; i < RD_DEPTH; i++) begin
      drive(0, read, '0, 1, DATA_W'(100 + i));
      step();
      check($sformatf("drain%0d", i), {request_done_valid, logic'(the_type), index, in_data},
            {1'b1, 1'b0, IDX_W'(i), DATA_W'(100 + i)});
    end
    idle();
    step();
    check("drained_rdo", rd_outstanding, 0);

    // Reset with reads and writes outstanding.
    drive(1, read, 6'd1, 0, '0);  step();
    drive(1, write, 6'd2, 0, '0); step();
    drive(1, read, 6'd3, 0, '0);  step();
    drive(1, write, 6'd4, 0, '0); step();
    drive(1, read, 6'd5, 0, '0);  step();
    idle();
    apply_reset(2);
    check("mid_reset_rdo", rd_outstanding, 0);
    for (int i = 0; i < WR_LAT + 4; i++) begin
      step();
      check($sformatf("post_reset_quiet%0d", i), {request_done_valid, err_unexpected}, 2'b00);
    end
    check("post_reset_ready", issue_ready, 1'b1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int rd_pct;
      rd_pct = ((c / 400) % 2 == 1) ? 10 : 55;
      if ($urandom_range(0, 599) == 0) begin
        idle();
        apply_reset(2);
      end
      drive($urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? write : read,
            IDX_W'($urandom),
            (rd_q.size() > 0) ? ($urandom_range(0, 99) < rd_pct)
                              : ($urandom_range(0, 99) < 2),
            DATA_W'($urandom));
      step();
    end
    idle();
    repeat (WR_LAT + 3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
